// File: rtl/spatial_encoder.sv
// ----------------------------------------------------------------------------
// spatial_encoder
//
// Per-modality spatial encoder. Each accepted channel beat binds the item-memory
// HV with the projection HV (bitwise XOR). All NUM_CHANNEL beats of a frame are
// bundled into one modality HV by per-bit majority, which is then offered on a
// valid/ready output port.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous, active-low reset
//   im          in   item-memory HV for the current channel
//   projm       in   projection HV for the current channel
//   din_valid   in   im/projm beat valid
//   din_ready   out  beat accepted this cycle (high for the whole accumulate phase)
//   dout        out  bundled modality HV
//   dout_valid  out  dout valid
//   dout_ready  in   downstream accepts dout
// ----------------------------------------------------------------------------
module spatial_encoder #(
    parameter int unsigned HV_DIMENSION = 2000,
    parameter int unsigned NUM_CHANNEL  = 32,
    parameter int unsigned CNT_WIDTH    = $clog2(NUM_CHANNEL + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [HV_DIMENSION-1:0] im,
    input  logic [HV_DIMENSION-1:0] projm,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [HV_DIMENSION-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    // Even frames (other than 2) get an extra tie-break vote so the majority
    // threshold is never hit exactly.
    localparam bit          USE_TIE = ((NUM_CHANNEL % 2) == 0) && (NUM_CHANNEL > 2);
    localparam int unsigned VOTE_W  = CNT_WIDTH + 2;
    localparam int unsigned THRESH  = USE_TIE ? NUM_CHANNEL + 1 : NUM_CHANNEL;

    localparam logic [VOTE_W:0]    THRESH_V  = (VOTE_W + 1)'(THRESH);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(NUM_CHANNEL - 1);

    typedef enum logic [0:0] {StAccum, StOutput} state_e;

    state_e                                 state_q;
    logic [CNT_WIDTH-1:0]                   beat_cnt_q;
    logic [HV_DIMENSION-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [HV_DIMENSION-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [HV_DIMENSION-1:0]                tie0_q;
    logic [HV_DIMENSION-1:0]                tie_q;
    logic [HV_DIMENSION-1:0]                dout_q;
    logic [HV_DIMENSION-1:0]                bound;
    logic [HV_DIMENSION-1:0]                maj;
    logic [VOTE_W-1:0]                      votes;
    logic                                   fire;
    logic                                   last_beat;

    assign din_ready  = (state_q == StAccum);
    assign dout_valid = (state_q == StOutput);
    assign dout       = dout_q;
    assign bound      = im ^ projm;
    assign fire       = din_valid && din_ready;
    assign last_beat  = (beat_cnt_q == LAST_BEAT);

    // Counter update and majority decision both include the current beat, so
    // the last beat's edge can register the final result directly.
    always_comb begin
        cnt_d = cnt_q;
        votes = '0;
        maj   = '0;
        for (int k = 0; k < HV_DIMENSION; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_WIDTH'(bound[k]);
            votes    = VOTE_W'(cnt_d[k]) + VOTE_W'(USE_TIE && tie_q[k]);
            maj[k]   = ({votes, 1'b0} > THRESH_V);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StAccum;
            beat_cnt_q <= '0;
            cnt_q      <= '0;
            tie0_q     <= '0;
            tie_q      <= '0;
            dout_q     <= '0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (fire) begin
                        cnt_q      <= cnt_d;
                        beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
                        if (beat_cnt_q == '0) begin
                            tie0_q <= bound;
                        end
                        if (beat_cnt_q == CNT_WIDTH'(1)) begin
                            tie_q <= tie0_q ^ bound;
                        end
                        if (last_beat) begin
                            dout_q  <= maj;
                            state_q <= StOutput;
                        end
                    end
                end
                StOutput: begin
                    // dout keeps its value; only the accumulation state clears.
                    if (dout_ready) begin
                        state_q    <= StAccum;
                        beat_cnt_q <= '0;
                        cnt_q      <= '0;
                        tie0_q     <= '0;
                        tie_q      <= '0;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

endmodule
